// File: rtl/dsp_logic_simd_pkg.sv
// Shared types and helpers for the dsp_logic_simd SIMD bitwise-logic unit.
// Optional parity output is enabled by defining DSP_LOGIC_SIMD_PARITY_EN.
package dsp_logic_simd_pkg;

  localparam int DSP_W = 48;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_ANDNOT = 3'd6,
    OP_PASS_A = 3'd7
  } op_t;

  // Lane width for a given lane count over the 48-bit DSP datapath.
  function automatic int lane_width(int lanes);
    return (lanes > 0) ? DSP_W / lanes : DSP_W;
  endfunction

  // Bitwise operation applied across a full DSP-width word.
  function automatic logic [DSP_W-1:0] apply_op(op_t op, logic [DSP_W-1:0] a,
                                                logic [DSP_W-1:0] b);
    logic [DSP_W-1:0] r;
    r = '0;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NAND:   r = ~(a & b);
      OP_NOR:    r = ~(a | b);
      OP_XNOR:   r = ~(a ^ b);
      OP_ANDNOT: r = a & ~b;
      OP_PASS_A: r = a;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dsp_logic_simd_if.sv
// Valid/ready stream bundle for dsp_logic_simd (input and output sides).
// out_parity exists only when DSP_LOGIC_SIMD_PARITY_EN is defined.
interface dsp_logic_simd_if #(
  parameter int LANES = 2,
  parameter int WIDTH = 24
);

  logic                   in_valid;
  logic                   in_ready;
  logic [2:0]             in_op;
  logic [LANES*WIDTH-1:0] in_a;
  logic [LANES*WIDTH-1:0] in_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_y;
`ifdef DSP_LOGIC_SIMD_PARITY_EN
  logic [LANES-1:0]       out_parity;
`endif

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y
`ifdef DSP_LOGIC_SIMD_PARITY_EN
    , input out_parity
`endif
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y
`ifdef DSP_LOGIC_SIMD_PARITY_EN
    , output out_parity
`endif
  );

endinterface

// File: rtl/dsp_logic_simd_slot.sv
// One elastic pipeline slot: holds a valid bit and a data word, loads when
// empty or when the downstream side is taking the current word.
module dsp_logic_simd_slot #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [DW-1:0] down_data
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  assign up_ready   = !valid_q || down_ready;
  assign down_valid = valid_q;
  assign down_data  = data_q;

  // Slot register; data only changes on an actual transfer so a pop leaves it stale.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (up_ready) begin
      valid_q <= up_valid;
      if (up_valid) data_q <= up_data;
    end
  end

endmodule

// File: rtl/dsp_logic_simd.sv
// SIMD bitwise-logic unit: 1/2/4 lanes over a 48-bit DSP datapath, op chosen
// per transaction, followed by a STAGES-deep elastic valid/ready pipeline.
// Define DSP_LOGIC_SIMD_PARITY_EN to add per-lane result parity (out_parity).
module dsp_logic_simd
  import dsp_logic_simd_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int WIDTH  = 24,
  parameter int STAGES = 1
) (
  input logic           clock,
  input logic           reset,
  dsp_logic_simd_if.slave bus
);

  localparam int LW = lane_width(LANES);
  localparam int YW = LANES * WIDTH;
`ifdef DSP_LOGIC_SIMD_PARITY_EN
  localparam int DW = YW + LANES;
`else
  localparam int DW = YW;
`endif

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("dsp_logic_simd: LANES must be 1, 2 or 4");
  end
  if (WIDTH < 1 || WIDTH > LW) begin : g_bad_width
    $error("dsp_logic_simd: WIDTH must be in 1..48/LANES");
  end
  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("dsp_logic_simd: STAGES must be in 1..3");
  end

  logic [LANES*LW-1:0] ext_a;
  logic [LANES*LW-1:0] ext_b;
  logic [LANES*LW-1:0] ext_res;
  logic [YW-1:0]       res;
  logic                unused_ext;

  // Per-lane sign extension to LW, lane operation, then keep the low WIDTH bits.
  always_comb begin
    ext_a   = '0;
    ext_b   = '0;
    ext_res = '0;
    res     = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      ext_a[k*LW +: LW]     = LW'($signed(bus.in_a[k*WIDTH +: WIDTH]));
      ext_b[k*LW +: LW]     = LW'($signed(bus.in_b[k*WIDTH +: WIDTH]));
      ext_res[k*LW +: LW]   = LW'(apply_op(op_t'(bus.in_op),
                                           DSP_W'(ext_a[k*LW +: LW]),
                                           DSP_W'(ext_b[k*LW +: LW])));
      res[k*WIDTH +: WIDTH] = ext_res[k*LW +: WIDTH];
    end
  end

  // Extension bits are computed to mirror the DSP lane but never leave the unit.
  assign unused_ext = ^ext_res;

  logic [STAGES:0]         v;
  logic [STAGES:0]         r;
  logic [STAGES:0][DW-1:0] d;

`ifdef DSP_LOGIC_SIMD_PARITY_EN
  logic [LANES-1:0] par;

  // Parity of each lane's WIDTH result bits, carried through the pipe with the data.
  always_comb begin
    par = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      par[k] = ^res[k*WIDTH +: WIDTH];
    end
  end

  assign d[0]           = {par, res};
  assign bus.out_parity = d[STAGES][DW-1:YW];
`else
  assign d[0] = res;
`endif

  assign v[0]          = bus.in_valid;
  assign r[STAGES]     = bus.out_ready;
  assign bus.in_ready  = r[0];
  assign bus.out_valid = v[STAGES];
  assign bus.out_y     = d[STAGES][YW-1:0];

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    dsp_logic_simd_slot #(.DW(DW)) u_slot (
      .clock      (clock),
      .reset      (reset),
      .up_valid   (v[i]),
      .up_ready   (r[i]),
      .up_data    (d[i]),
      .down_valid (v[i+1]),
      .down_ready (r[i+1]),
      .down_data  (d[i+1])
    );
  end

endmodule

// File: tb/tb_dsp_logic_simd.sv
// Directed self-checking bench for dsp_logic_simd across several configurations.
// Parity checks are included when DSP_LOGIC_SIMD_PARITY_EN is defined.
module tb_dsp_logic_simd;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dsp_logic_simd_if #(.LANES(2), .WIDTH(24)) b0 ();
  dsp_logic_simd_if #(.LANES(4), .WIDTH(8))  b1 ();
  dsp_logic_simd_if #(.LANES(2), .WIDTH(24)) b2 ();
  dsp_logic_simd_if #(.LANES(1), .WIDTH(16)) b3 ();

  dsp_logic_simd #(.LANES(2), .WIDTH(24), .STAGES(1)) u0 (.clock(clk), .reset(rst_n), .bus(b0));
  dsp_logic_simd #(.LANES(4), .WIDTH(8),  .STAGES(2)) u1 (.clock(clk), .reset(rst_n), .bus(b1));
  dsp_logic_simd #(.LANES(2), .WIDTH(24), .STAGES(3)) u2 (.clock(clk), .reset(rst_n), .bus(b2));
  dsp_logic_simd #(.LANES(1), .WIDTH(16), .STAGES(1)) u3 (.clock(clk), .reset(rst_n), .bus(b3));

`ifdef DSP_LOGIC_SIMD_PARITY_EN
  dsp_logic_simd_if #(.LANES(2), .WIDTH(4)) b4 ();
  dsp_logic_simd #(.LANES(2), .WIDTH(4), .STAGES(1)) u4 (.clock(clk), .reset(rst_n), .bus(b4));
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] ops_exp [8] = '{32'h05050505, 32'hAFAFAFAF, 32'hAAAAAAAA, 32'hFAFAFAFA,
                               32'h50505050, 32'h55555555, 32'hA0A0A0A0, 32'hA5A5A5A5};
  logic [47:0] bp_vals [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx;
    int   nout;
    logic rdy;
    logic ov;
    logic [47:0] oy;
    logic seen;

    total = 0;
    bad   = 0;
    for (int k = 0; k < 5; k++) bp_vals[k] = {24'(k + 1), 24'(16 + k)};

    b0.in_valid = 0; b0.in_op = '0; b0.in_a = '0; b0.in_b = '0; b0.out_ready = 1;
    b1.in_valid = 0; b1.in_op = '0; b1.in_a = '0; b1.in_b = '0; b1.out_ready = 1;
    b2.in_valid = 0; b2.in_op = '0; b2.in_a = '0; b2.in_b = '0; b2.out_ready = 1;
    b3.in_valid = 0; b3.in_op = '0; b3.in_a = '0; b3.in_b = '0; b3.out_ready = 1;
`ifdef DSP_LOGIC_SIMD_PARITY_EN
    b4.in_valid = 0; b4.in_op = '0; b4.in_a = '0; b4.in_b = '0; b4.out_ready = 1;
`endif

    // Reset state
    rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", b0.out_valid, 0);
    check("rst_out_y", b0.out_y, 0);
    check("rst_in_ready", b0.in_ready, 1);
    check("rst_out_valid_s2", b1.out_valid, 0);
    rst_n = 1;
    #1 check("post_rst_in_ready", b0.in_ready, 1);

    // Single OR transaction, STAGES=1
    @(negedge clk);
    b0.in_valid = 1; b0.in_op = 3'd1;
    b0.in_a = {24'h0F0F0F, 24'h000001};
    b0.in_b = {24'hF00000, 24'h000010};
    @(negedge clk);
    b0.in_valid = 0;
    check("or_valid", b0.out_valid, 1);
    check("or_y", b0.out_y, 48'hFF0F0F000011);
    @(negedge clk);
    check("or_drained", b0.out_valid, 0);

    // All eight ops back-to-back, LANES=4 WIDTH=8 STAGES=2
    for (int c = 0; c < 9; c++) begin
      if (c < 8) begin
        b1.in_valid = 1; b1.in_op = 3'(c);
        b1.in_a = 32'hA5A5A5A5; b1.in_b = 32'h0F0F0F0F;
      end else begin
        b1.in_valid = 0;
      end
      @(negedge clk);
      if (c == 0) check("ops_latency", b1.out_valid, 0);
      else begin
        check($sformatf("ops_valid_%0d", c - 1), b1.out_valid, 1);
        check($sformatf("ops_y_%0d", c - 1), b1.out_y, ops_exp[c - 1]);
      end
    end
    @(negedge clk);
    check("ops_drained", b1.out_valid, 0);

    // Backpressure, STAGES=3: stall, then drain
    b2.out_ready = 0;
    b2.in_op = 3'd7;
    b2.in_b = '0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      b2.in_valid = (idx < 5);
      b2.in_a = bp_vals[(idx < 5) ? idx : 0];
      #1 rdy = b2.in_ready;
      @(negedge clk);
      if (rdy && b2.in_valid) idx++;
      if (c >= 3) check("bp_stall_y", b2.out_y, bp_vals[0]);
    end
    check("bp_accepts", idx, 3);
    #1;
    check("bp_in_ready", b2.in_ready, 0);
    check("bp_out_valid", b2.out_valid, 1);

    b2.out_ready = 1;
    nout = 0;
    for (int c = 0; c < 12; c++) begin
      b2.in_valid = (idx < 5);
      if (idx < 5) b2.in_a = bp_vals[idx];
      #1;
      rdy = b2.in_ready;
      ov  = b2.out_valid;
      oy  = b2.out_y;
      if (ov && nout < 5) check($sformatf("bp_order_%0d", nout), oy, bp_vals[nout]);
      if (ov) nout++;
      @(negedge clk);
      if (rdy && b2.in_valid) idx++;
    end
    check("bp_out_count", nout, 5);
    check("bp_in_count", idx, 5);
    check("bp_drained", b2.out_valid, 0);

    // Sign extension does not leak, LANES=1 WIDTH=16, NOR
    b3.in_valid = 1; b3.in_op = 3'd4; b3.in_a = 16'h8000; b3.in_b = 16'h0000;
    @(negedge clk);
    b3.in_valid = 0;
    check("sext_valid", b3.out_valid, 1);
    check("sext_y", b3.out_y, 16'h7FFF);

`ifdef DSP_LOGIC_SIMD_PARITY_EN
    // Per-lane parity, LANES=2 WIDTH=4, XOR with zero
    b4.in_valid = 1; b4.in_op = 3'd2; b4.in_a = 8'h71; b4.in_b = 8'h00;
    @(negedge clk);
    check("par_11", b4.out_parity, 2'b11);
    check("par_y", b4.out_y, 8'h71);
    b4.in_a = 8'h30;
    @(negedge clk);
    b4.in_valid = 0;
    check("par_00", b4.out_parity, 2'b00);
`endif

    // Asynchronous reset mid-flight, STAGES=2
    b1.out_ready = 0;
    b1.in_valid = 1; b1.in_op = 3'd1; b1.in_a = 32'h11223344; b1.in_b = 32'h0;
    @(negedge clk);
    b1.in_a = 32'h55667788;
    @(negedge clk);
    b1.in_valid = 0;
    check("mid_valid_before", b1.out_valid, 1);
    #2 rst_n = 0;
    #1;
    check("mid_valid_async", b1.out_valid, 0);
    check("mid_y_async", b1.out_y, 0);
    @(negedge clk);
    rst_n = 1;
    b1.out_ready = 1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (b1.out_valid) seen = 1;
    end
    check("mid_no_output", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
